// File: rtl/adc_conv_sched_if.sv
// Signal bundle between the ADC conversion scheduler, its requesters, the converter and result consumers.
// master = scheduler side, slave = environment side (PWM timer, converter, control loop).
`timescale 1ns/1ps
interface adc_conv_sched_if #(
   parameter int ADC_W = 12,
   parameter int N_CH  = 8
);
   localparam int CW = $clog2(N_CH);

   logic              en;
   logic              pwm_sync;
   logic [N_CH-1:0]   fast_mask;
   logic [N_CH-1:0]   slow_mask;
   logic              conv_wr;
   logic [CW-1:0]     conv_chnl;
   logic              conv_rdy;
   logic [ADC_W-1:0]  conv_data;
   logic              res_val;
   logic [CW-1:0]     res_chnl;
   logic [ADC_W-1:0]  res_data;
   logic              res_fast;
   logic              burst_done;
   logic              overrun;
   logic              timeout;

   modport master (
      input  en, pwm_sync, fast_mask, slow_mask, conv_rdy, conv_data,
      output conv_wr, conv_chnl, res_val, res_chnl, res_data, res_fast,
             burst_done, overrun, timeout
   );

   modport slave (
      output en, pwm_sync, fast_mask, slow_mask, conv_rdy, conv_data,
      input  conv_wr, conv_chnl, res_val, res_chnl, res_data, res_fast,
             burst_done, overrun, timeout
   );
endinterface

// File: rtl/adc_conv_sched.sv
// Shares one serial ADC between a PWM-synchronous fast burst and a background slow round-robin.
// Latency: conv_wr 1 cycle after ISSUE; result 1 cycle after conv_rdy. No preemption; fast waits at most one conversion + 2 cycles.
`timescale 1ns/1ps
module adc_conv_sched #(
   parameter int ADC_W  = 12,
   parameter int N_CH   = 8,
   parameter int TO_CYC = 4096
) (
   input  logic               clk,
   input  logic               rstn,
   adc_conv_sched_if.master   bus
);
   localparam int CW = $clog2(N_CH);
   localparam int TW = $clog2(TO_CYC + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [N_CH-1:0]   fast_pend_q, fast_pend_d;
   logic [CW-1:0]     slow_ptr_q, slow_ptr_d;
   logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
   logic              conv_wr_q, conv_wr_d;
   logic [CW-1:0]     conv_chnl_q, conv_chnl_d;
   logic              is_fast_q, is_fast_d;
   logic              res_val_q, res_val_d;
   logic [CW-1:0]     res_chnl_q, res_chnl_d;
   logic [ADC_W-1:0]  res_data_q, res_data_d;
   logic              res_fast_q, res_fast_d;
   logic              burst_done_q, burst_done_d;
   logic              overrun_q, overrun_d;
   logic              timeout_q, timeout_d;

   logic [CW-1:0]     fast_sel;
   logic [CW-1:0]     slow_sel;
   logic [CW-1:0]     slow_idx;
   logic              slow_found;
   logic              fast_job;
   logic              job;
   logic [N_CH-1:0]   fast_clr;
   logic              rdy_clr;
   logic [N_CH-1:0]   pend_cleared;

   // Channel selection: lowest pending fast bit; first slow bit at/after slow_ptr with wrap.
   always_comb begin
      fast_sel   = '0;
      slow_sel   = '0;
      slow_idx   = '0;
      slow_found = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (fast_pend_q[i]) fast_sel = CW'(i);
      end
      for (int i = 0; i < N_CH; i++) begin
         slow_idx = CW'((int'(slow_ptr_q) + i) % N_CH);
         if (!slow_found && bus.slow_mask[slow_idx]) begin
            slow_sel   = slow_idx;
            slow_found = 1'b1;
         end
      end
   end

   assign fast_job = |fast_pend_q;
   assign job      = fast_job || (|bus.slow_mask);

   always_comb begin
      state_d      = state_q;
      slow_ptr_d   = slow_ptr_q;
      wait_cnt_d   = wait_cnt_q;
      conv_wr_d    = 1'b0;
      conv_chnl_d  = conv_chnl_q;
      is_fast_d    = is_fast_q;
      res_val_d    = 1'b0;
      res_chnl_d   = res_chnl_q;
      res_data_d   = res_data_q;
      res_fast_d   = res_fast_q;
      burst_done_d = 1'b0;
      overrun_d    = 1'b0;
      timeout_d    = 1'b0;
      fast_clr     = '0;
      rdy_clr      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.en && job) state_d = ISSUE;
         end
         ISSUE: begin
            wait_cnt_d = '0;
            if (fast_job) begin
               conv_chnl_d = fast_sel;
               is_fast_d   = 1'b1;
               conv_wr_d   = 1'b1;
               state_d     = WAIT;
            end else if (slow_found) begin
               conv_chnl_d = slow_sel;
               is_fast_d   = 1'b0;
               conv_wr_d   = 1'b1;
               state_d     = WAIT;
            end else begin
               // slow_mask dropped to zero between DONE and ISSUE
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (bus.conv_rdy) begin
               res_val_d  = 1'b1;
               res_chnl_d = conv_chnl_q;
               res_data_d = bus.conv_data;
               res_fast_d = is_fast_q;
               wait_cnt_d = '0;
               state_d    = DONE;
               if (is_fast_q) begin
                  fast_clr[conv_chnl_q] = 1'b1;
                  rdy_clr               = 1'b1;
               end else begin
                  slow_ptr_d = CW'((int'(conv_chnl_q) + 1) % N_CH);
               end
            end else if (wait_cnt_q == TW'(TO_CYC - 1)) begin
               // Give up on this channel; slow_ptr stays so the slow channel is retried
               timeout_d  = 1'b1;
               wait_cnt_d = '0;
               state_d    = IDLE;
               if (is_fast_q) fast_clr[conv_chnl_q] = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + TW'(1);
            end
         end
         DONE: begin
            state_d = (bus.en && job) ? ISSUE : IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Completion clear lands before a coincident pwm_sync reload
      pend_cleared = fast_pend_q & ~fast_clr;
      burst_done_d = rdy_clr && fast_job && !(|pend_cleared);
      fast_pend_d  = pend_cleared;
      if (bus.pwm_sync && (|bus.fast_mask)) begin
         if (|pend_cleared) begin
            fast_pend_d = pend_cleared | bus.fast_mask;
            overrun_d   = 1'b1;
         end else begin
            fast_pend_d = bus.fast_mask;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         fast_pend_q  <= '0;
         slow_ptr_q   <= '0;
         wait_cnt_q   <= '0;
         conv_wr_q    <= 1'b0;
         conv_chnl_q  <= '0;
         is_fast_q    <= 1'b0;
         res_val_q    <= 1'b0;
         res_chnl_q   <= '0;
         res_data_q   <= '0;
         res_fast_q   <= 1'b0;
         burst_done_q <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         fast_pend_q  <= fast_pend_d;
         slow_ptr_q   <= slow_ptr_d;
         wait_cnt_q   <= wait_cnt_d;
         conv_wr_q    <= conv_wr_d;
         conv_chnl_q  <= conv_chnl_d;
         is_fast_q    <= is_fast_d;
         res_val_q    <= res_val_d;
         res_chnl_q   <= res_chnl_d;
         res_data_q   <= res_data_d;
         res_fast_q   <= res_fast_d;
         burst_done_q <= burst_done_d;
         overrun_q    <= overrun_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.conv_wr    = conv_wr_q;
   assign bus.conv_chnl  = conv_chnl_q;
   assign bus.res_val    = res_val_q;
   assign bus.res_chnl   = res_chnl_q;
   assign bus.res_data   = res_data_q;
   assign bus.res_fast   = res_fast_q;
   assign bus.burst_done = burst_done_q;
   assign bus.overrun    = overrun_q;
   assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_adc_conv_sched.sv
// Scoreboard bench for adc_conv_sched: directed scenarios push expected results, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_adc_conv_sched;
   localparam int ADC_W  = 12;
   localparam int N_CH   = 8;
   localparam int TO_CYC = 64;

   typedef struct {
      logic [2:0]  ch;
      logic [11:0] data;
      bit          fast;
      bit          bd;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;

   adc_conv_sched_if #(.ADC_W(ADC_W), .N_CH(N_CH)) bus();

   adc_conv_sched #(.ADC_W(ADC_W), .N_CH(N_CH), .TO_CYC(TO_CYC)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc = 0, wr_cnt = 0, ov_cnt = 0, to_cnt = 0, wr_cyc = 0, to_lat = 0;
   bit   mdl_dead = 1'b0;
   int   base, ov_base, to_base;

   function automatic logic [31:0] enc(logic [2:0] ch, bit f, bit b, logic [11:0] d);
      return {13'b0, ch, f, b, 2'b0, d};
   endfunction

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic exp_push(input int ch, input bit fast, input bit bd);
      exp_t e;
      e.ch   = 3'(ch);
      e.data = 12'(ch * 100);
      e.fast = fast;
      e.bd   = bd;
      sb.push_back(e);
   endtask

   task automatic pulse_pwm();
      @(negedge clk) bus.pwm_sync = 1'b1;
      @(negedge clk) bus.pwm_sync = 1'b0;
   endtask

   task automatic wait_wr(input int n, input int lim, input string name);
      int k = 0;
      while (wr_cnt < n && k < lim) begin @(negedge clk); k++; end
      chk(wr_cnt >= n, name, wr_cnt, n);
   endtask

   task automatic wait_empty(input int lim, input string name);
      int k = 0;
      while (sb.size() != 0 && k < lim) begin @(negedge clk); k++; end
      chk(sb.size() == 0, name, sb.size(), 0);
   endtask

   task automatic chk_zero(input string name);
      logic [31:0] v;
      #1;
      v = 32'({bus.conv_wr, bus.conv_chnl, bus.res_val, bus.res_chnl, bus.res_data,
               bus.res_fast, bus.burst_done, bus.overrun, bus.timeout});
      chk(v == 0, name, v, 0);
   endtask

   // Monitor: event counters and scoreboard check on every result strobe
   always @(negedge clk) begin
      cyc++;
      if (rstn) begin
         if (bus.conv_wr) begin wr_cnt++; wr_cyc = cyc; end
         if (bus.overrun) ov_cnt++;
         if (bus.timeout) begin to_cnt++; to_lat = cyc - wr_cyc; end
         if (bus.res_val) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_res",
                   enc(bus.res_chnl, bus.res_fast, bus.burst_done, bus.res_data), 0);
            end else begin
               mon_e = sb.pop_front();
               chk(enc(bus.res_chnl, bus.res_fast, bus.burst_done, bus.res_data) ==
                   enc(mon_e.ch, mon_e.fast, mon_e.bd, mon_e.data), "res",
                   enc(bus.res_chnl, bus.res_fast, bus.burst_done, bus.res_data),
                   enc(mon_e.ch, mon_e.fast, mon_e.bd, mon_e.data));
            end
         end
      end
   end

   // Converter model: result ch*100 twenty cycles after the start strobe
   initial begin
      logic [2:0] mch;
      int n;
      bus.conv_rdy  = 1'b0;
      bus.conv_data = '0;
      forever begin
         @(negedge clk);
         if (rstn && bus.conv_wr && !mdl_dead) begin
            mch = bus.conv_chnl;
            n = 0;
            while (n < 20 && rstn) begin @(negedge clk); n++; end
            if (rstn) begin
               bus.conv_rdy  = 1'b1;
               bus.conv_data = 12'(mch * 100);
               @(negedge clk);
               bus.conv_rdy  = 1'b0;
            end
         end
      end
   end

   initial begin
      bus.en        = 1'b0;
      bus.pwm_sync  = 1'b0;
      bus.fast_mask = '0;
      bus.slow_mask = '0;
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset_outputs");
      @(negedge clk) rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Fast burst over channels 0..2
      exp_push(0, 1, 0); exp_push(1, 1, 0); exp_push(2, 1, 1);
      bus.fast_mask = 8'h07;
      bus.en = 1'b1;
      pulse_pwm();
      wait_empty(400, "t2_drain");
      chk(ov_cnt == 0, "t2_overrun", ov_cnt, 0);

      // Background round-robin over channels 5 and 7
      bus.fast_mask = '0;
      base = wr_cnt;
      exp_push(5, 0, 0); exp_push(7, 0, 0); exp_push(5, 0, 0); exp_push(7, 0, 0);
      bus.slow_mask = 8'hA0;
      wait_wr(base + 4, 600, "t3_issue");
      bus.en = 1'b0;
      wait_empty(200, "t3_drain");
      repeat (10) @(negedge clk);
      chk(wr_cnt == base + 4, "t3_wr_count", wr_cnt, base + 4);

      // Fast request during a slow conversion waits for it
      base = wr_cnt;
      exp_push(5, 0, 0); exp_push(0, 1, 1); exp_push(7, 0, 0);
      bus.fast_mask = 8'h01;
      bus.en = 1'b1;
      wait_wr(base + 1, 50, "t4_first");
      repeat (5) @(negedge clk);
      pulse_pwm();
      wait_wr(base + 3, 300, "t4_issue");
      bus.en = 1'b0;
      wait_empty(200, "t4_drain");
      repeat (10) @(negedge clk);
      chk(wr_cnt == base + 3, "t4_wr_count", wr_cnt, base + 3);

      // Overrun: second pwm_sync while ch1 is converting
      bus.slow_mask = '0;
      bus.fast_mask = 8'h03;
      base = wr_cnt;
      ov_base = ov_cnt;
      exp_push(0, 1, 0); exp_push(1, 1, 0); exp_push(0, 1, 1);
      bus.en = 1'b1;
      pulse_pwm();
      wait_wr(base + 2, 200, "t5_ch1");
      repeat (5) @(negedge clk);
      pulse_pwm();
      wait_empty(300, "t5_drain");
      repeat (30) @(negedge clk);
      chk(ov_cnt == ov_base + 1, "t5_overrun", ov_cnt, ov_base + 1);
      chk(wr_cnt == base + 3, "t5_wr_count", wr_cnt, base + 3);

      // Timeout: converter never answers
      mdl_dead = 1'b1;
      bus.fast_mask = 8'h04;
      base = wr_cnt;
      to_base = to_cnt;
      pulse_pwm();
      begin
         int k = 0;
         while (to_cnt == to_base && k < 200) begin @(negedge clk); k++; end
      end
      chk(to_cnt == to_base + 1, "t6_timeout", to_cnt, to_base + 1);
      chk(to_lat == 64, "t6_latency", to_lat, 64);
      bus.fast_mask = '0;
      repeat (20) @(negedge clk);
      chk(wr_cnt == base + 1, "t6_no_reissue", wr_cnt, base + 1);
      mdl_dead = 1'b0;
      exp_push(3, 0, 0);
      bus.slow_mask = 8'h08;
      wait_wr(base + 2, 50, "t6_next_job");
      bus.en = 1'b0;
      wait_empty(200, "t6_drain");

      // Reset in the middle of a conversion
      bus.slow_mask = 8'h01;
      bus.en = 1'b1;
      base = wr_cnt;
      wait_wr(base + 1, 50, "t1_issue");
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      chk_zero("t1_reset_mid_wait");
      bus.en = 1'b0;
      @(negedge clk) rstn = 1'b1;
      repeat (30) @(negedge clk);
      chk(wr_cnt == base + 1, "t1_idle_after_reset", wr_cnt, base + 1);
      chk(sb.size() == 0, "final_queue", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
